// File: rtl/hdmi_pkg.sv
// hdmi_pkg
// Shared definitions for the HDMI island scheduler: TMDS period codes,
// island FSM state encoding, CTL preamble patterns and period lengths.
// Ports: none (package).
package hdmi_pkg;

    typedef enum logic [2:0] {
        PER_CTRL    = 3'd0,
        PER_DI_PRE  = 3'd1,
        PER_DI_GB   = 3'd2,
        PER_DI_DATA = 3'd3,
        PER_VID_PRE = 3'd4,
        PER_VID_GB  = 3'd5,
        PER_VIDEO   = 3'd6
    } period_t;

    typedef enum logic [2:0] {
        ST_CTRL,
        ST_DI_PRE,
        ST_DI_GB_LEAD,
        ST_DI_DATA,
        ST_DI_GB_TRAIL
    } island_state_t;

    localparam logic [3:0] CTL_DI_PRE  = 4'b0101;
    localparam logic [3:0] CTL_VID_PRE = 4'b0001;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PKT_BEATS    = 32;
    localparam int CTRL_MIN     = 12;

    // CTL3..0 pattern carried during a given period
    function automatic logic [3:0] ctl_for(input period_t p);
        logic [3:0] v;
        v = 4'b0000;
        if (p == PER_DI_PRE)  v = CTL_DI_PRE;
        if (p == PER_VID_PRE) v = CTL_VID_PRE;
        return v;
    endfunction

endpackage

// File: rtl/hdmi_island_scheduler_rr_arbiter.sv
// hdmi_island_scheduler_rr_arbiter
// Round-robin arbiter: combinational one-hot grant searching from the
// current pointer, plus the pointer register itself.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset (pointer -> 0)
//   i_req         per-source request vector
//   i_adv         decision point; pointer moves to winner+1 when a winner exists
//   o_gnt         one-hot grant for the current request vector
//   o_found       at least one request present
module hdmi_island_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_adv,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_found
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] N_W = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W-1:0]     r_ptr;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [PTR_W-1:0]     w_off;
    logic [PTR_W-1:0]     w_win;
    logic [PTR_W-1:0]     w_next;
    logic [PTR_W:0]       w_sum;
    logic [PTR_W:0]       w_sum1;

    always_comb begin
        // rotate so bit 0 is the source at the pointer; lowest set bit wins
        w_dbl   = {i_req, i_req};
        w_rot   = w_dbl[{1'b0, r_ptr} +: NUM_REQ];
        o_found = 1'b0;
        w_off   = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_found = 1'b1;
                w_off   = PTR_W'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= N_W) w_sum = w_sum - N_W;
        w_win  = w_sum[PTR_W-1:0];
        w_sum1 = {1'b0, w_win} + (PTR_W+1)'(1);
        if (w_sum1 >= N_W) w_sum1 = '0;
        w_next = w_sum1[PTR_W-1:0];
        o_gnt  = o_found ? (NUM_REQ'(1) << w_win) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_adv && o_found) begin
            r_ptr <= w_next;
        end
    end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// hdmi_island_scheduler
// Chooses the TMDS period for every pixel clock (control, data-island
// preamble/guard/packet, video preamble/guard, active video) from the video
// timing counters, and schedules round-robin packet islands in horizontal
// blanking. All outputs are registered: the value for counter X appears on
// the edge after X is presented.
// Ports:
//   i_clk, i_rst            pixel clock, synchronous active-high reset
//   i_counterX, i_counterY  timing generator counters
//   i_req                   per-source packet request (level)
//   o_period                period code (hdmi_pkg::period_t)
//   o_ctl                   CTL3..0 preamble pattern
//   o_gnt                   one-hot grant, held for the 32 beats of a packet
//   o_pkt_idx               packet beat 0..31 (0 outside DI_DATA)
//   o_pkt_first/o_pkt_last  beat 0 / beat 31 markers
//   o_abort                 one-cycle pulse when an island is cut short
//
// state          | meaning
// ST_CTRL        | no island; period follows video timing
// ST_DI_PRE      | 8-cycle data-island preamble
// ST_DI_GB_LEAD  | 2-cycle leading guard band; grant decided on its last cycle
// ST_DI_DATA     | 32-beat packet(s), back to back up to MAX_PKTS
// ST_DI_GB_TRAIL | 2-cycle trailing guard band
module hdmi_island_scheduler
    import hdmi_pkg::*;
#(
    parameter int RES_WIDTH     = 800,
    parameter int RES_HEIGHT    = 525,
    parameter int ACTIVE_X      = 640,
    parameter int ACTIVE_Y      = 480,
    parameter int ISLAND_START  = 652,
    parameter int MAX_PKTS      = 2,
    parameter int NUM_REQ       = 4,
    parameter int COUNTER_WIDTH = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [COUNTER_WIDTH-1:0] i_counterX,
    input  logic [COUNTER_WIDTH-1:0] i_counterY,
    input  logic [NUM_REQ-1:0]       i_req,
    output logic [2:0]               o_period,
    output logic [3:0]               o_ctl,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [4:0]               o_pkt_idx,
    output logic                     o_pkt_first,
    output logic                     o_pkt_last,
    output logic                     o_abort
);

    if (ISLAND_START < ACTIVE_X + CTRL_MIN) begin : g_chk_start
        $fatal(1, "ISLAND_START too close to end of active video");
    end
    if (ISLAND_START + PREAMBLE_LEN + 2*GUARD_LEN + PKT_BEATS*MAX_PKTS
        > RES_WIDTH - 10 - CTRL_MIN) begin : g_chk_len
        $fatal(1, "island with MAX_PKTS packets overruns the abort point");
    end
    if (MAX_PKTS < 1 || MAX_PKTS > 18) begin : g_chk_pkts
        $fatal(1, "MAX_PKTS must be 1..18");
    end

    localparam logic [COUNTER_WIDTH-1:0] X_ACT     = COUNTER_WIDTH'(ACTIVE_X);
    localparam logic [COUNTER_WIDTH-1:0] X_ISL     = COUNTER_WIDTH'(ISLAND_START);
    localparam logic [COUNTER_WIDTH-1:0] X_ABORT   = COUNTER_WIDTH'(RES_WIDTH - 10 - CTRL_MIN);
    localparam logic [COUNTER_WIDTH-1:0] X_VPRE_LO = COUNTER_WIDTH'(RES_WIDTH - 10);
    localparam logic [COUNTER_WIDTH-1:0] X_VPRE_HI = COUNTER_WIDTH'(RES_WIDTH - 3);
    localparam logic [COUNTER_WIDTH-1:0] X_VGB_LO  = COUNTER_WIDTH'(RES_WIDTH - 2);
    localparam logic [COUNTER_WIDTH-1:0] X_LAST    = COUNTER_WIDTH'(RES_WIDTH - 1);
    localparam logic [COUNTER_WIDTH-1:0] Y_ACT     = COUNTER_WIDTH'(ACTIVE_Y);
    localparam logic [COUNTER_WIDTH-1:0] Y_PRE_LIM = COUNTER_WIDTH'(ACTIVE_Y - 1);
    localparam logic [COUNTER_WIDTH-1:0] Y_LAST    = COUNTER_WIDTH'(RES_HEIGHT - 1);
    localparam logic [2:0] TMR_PRE     = 3'(PREAMBLE_LEN - 1);
    localparam logic [2:0] TMR_GB      = 3'(GUARD_LEN - 1);
    localparam logic [4:0] IDX_LAST    = 5'(PKT_BEATS - 1);
    localparam logic [4:0] IDX_PRELAST = 5'(PKT_BEATS - 2);
    localparam logic [4:0] PKTS_MAX    = 5'(MAX_PKTS);

    island_state_t      r_state;
    period_t            r_period;
    logic [2:0]         r_tmr;
    logic [4:0]         r_pkt_idx;
    logic [4:0]         r_pkt_cnt;
    logic               r_first;
    logic               r_last;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_abort;

    period_t            w_base_period;
    logic               w_next_line_act;
    logic               w_abort;
    logic               w_start;
    logic               w_lead_done;
    logic               w_pkt_end;
    logic               w_more_ok;
    logic               w_arb_adv;
    logic [NUM_REQ-1:0] w_arb_gnt;
    logic               w_arb_found;

    // period when no island is in progress
    always_comb begin
        w_next_line_act = (i_counterY < Y_PRE_LIM) || (i_counterY == Y_LAST);
        w_base_period   = PER_CTRL;
        if (i_counterX < X_ACT && i_counterY < Y_ACT)
            w_base_period = PER_VIDEO;
        else if (w_next_line_act && i_counterX >= X_VPRE_LO && i_counterX <= X_VPRE_HI)
            w_base_period = PER_VID_PRE;
        else if (w_next_line_act && i_counterX >= X_VGB_LO && i_counterX <= X_LAST)
            w_base_period = PER_VID_GB;
    end

    assign w_abort     = (i_counterX == X_ABORT) && (r_state != ST_CTRL);
    assign w_start     = (r_state == ST_CTRL) && (i_counterX == X_ISL) && (|i_req);
    assign w_lead_done = (r_state == ST_DI_GB_LEAD) && (r_tmr == '0);
    assign w_pkt_end   = (r_state == ST_DI_DATA) && (r_pkt_idx == IDX_LAST);
    assign w_more_ok   = (r_pkt_cnt < PKTS_MAX);
    assign w_arb_adv   = !w_abort && (w_lead_done || (w_pkt_end && w_more_ok));

    hdmi_island_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req),
        .i_adv   (w_arb_adv),
        .o_gnt   (w_arb_gnt),
        .o_found (w_arb_found)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_CTRL;
            r_period  <= PER_CTRL;
            r_tmr     <= '0;
            r_pkt_idx <= '0;
            r_pkt_cnt <= '0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_gnt     <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            if (w_abort) begin
                r_state   <= ST_CTRL;
                r_period  <= w_base_period;
                r_tmr     <= '0;
                r_pkt_idx <= '0;
                r_gnt     <= '0;
                r_abort   <= 1'b1;
            end else begin
                unique case (r_state)
                    ST_CTRL: begin
                        if (w_start) begin
                            r_state   <= ST_DI_PRE;
                            r_period  <= PER_DI_PRE;
                            r_tmr     <= TMR_PRE;
                            r_pkt_cnt <= '0;
                        end else begin
                            r_period  <= w_base_period;
                        end
                    end
                    ST_DI_PRE: begin
                        if (r_tmr == '0) begin
                            r_state  <= ST_DI_GB_LEAD;
                            r_period <= PER_DI_GB;
                            r_tmr    <= TMR_GB;
                        end else begin
                            r_tmr    <= r_tmr - 3'd1;
                        end
                    end
                    ST_DI_GB_LEAD: begin
                        if (r_tmr != '0) begin
                            r_tmr <= r_tmr - 3'd1;
                        end else if (w_arb_found) begin
                            r_state   <= ST_DI_DATA;
                            r_period  <= PER_DI_DATA;
                            r_pkt_idx <= '0;
                            r_first   <= 1'b1;
                            r_gnt     <= w_arb_gnt;
                            r_pkt_cnt <= 5'd1;
                        end else begin
                            // requests vanished during the preamble: close the island empty
                            r_state  <= ST_DI_GB_TRAIL;
                            r_tmr    <= TMR_GB;
                        end
                    end
                    ST_DI_DATA: begin
                        if (r_pkt_idx != IDX_LAST) begin
                            r_pkt_idx <= r_pkt_idx + 5'd1;
                            r_last    <= (r_pkt_idx == IDX_PRELAST);
                        end else if (w_more_ok && w_arb_found) begin
                            r_pkt_idx <= '0;
                            r_first   <= 1'b1;
                            r_gnt     <= w_arb_gnt;
                            r_pkt_cnt <= r_pkt_cnt + 5'd1;
                        end else begin
                            r_state   <= ST_DI_GB_TRAIL;
                            r_period  <= PER_DI_GB;
                            r_tmr     <= TMR_GB;
                            r_pkt_idx <= '0;
                            r_gnt     <= '0;
                        end
                    end
                    ST_DI_GB_TRAIL: begin
                        if (r_tmr == '0) begin
                            r_state  <= ST_CTRL;
                            r_period <= w_base_period;
                        end else begin
                            r_tmr    <= r_tmr - 3'd1;
                        end
                    end
                    default: begin
                        r_state  <= ST_CTRL;
                        r_period <= PER_CTRL;
                        r_gnt    <= '0;
                    end
                endcase
            end
        end
    end

    assign o_period    = r_period;
    assign o_ctl       = ctl_for(r_period);
    assign o_gnt       = r_gnt;
    assign o_pkt_idx   = r_pkt_idx;
    assign o_pkt_first = r_first;
    assign o_pkt_last  = r_last;
    assign o_abort     = r_abort;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Bench for hdmi_island_scheduler. Each line is planned up front by a
// reference model (island timing as arithmetic offsets from ISLAND_START,
// round-robin over outstanding packet counts), then driven cycle by cycle
// while requester models keep i_req high while they still owe packets.
module tb_hdmi_island_scheduler;

    localparam int RW   = 800;
    localparam int RH   = 525;
    localparam int AX   = 640;
    localparam int AY   = 480;
    localparam int IS   = 652;
    localparam int MAXP = 2;
    localparam int NR   = 4;
    localparam int CW   = 10;
    localparam int NONE = 1000;

    logic          clk;
    logic          rst;
    logic [CW-1:0] cx;
    logic [CW-1:0] cy;
    logic [NR-1:0] req;
    logic [2:0]    o_period;
    logic [3:0]    o_ctl;
    logic [NR-1:0] o_gnt;
    logic [4:0]    o_pkt_idx;
    logic          o_pkt_first;
    logic          o_pkt_last;
    logic          o_abort;

    hdmi_island_scheduler #(
        .RES_WIDTH(RW), .RES_HEIGHT(RH), .ACTIVE_X(AX), .ACTIVE_Y(AY),
        .ISLAND_START(IS), .MAX_PKTS(MAXP), .NUM_REQ(NR), .COUNTER_WIDTH(CW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_counterX(cx), .i_counterY(cy), .i_req(req),
        .o_period(o_period), .o_ctl(o_ctl), .o_gnt(o_gnt), .o_pkt_idx(o_pkt_idx),
        .o_pkt_first(o_pkt_first), .o_pkt_last(o_pkt_last), .o_abort(o_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int pend[NR];
    int mptr = 0;
    int e_per[RW];
    int e_gnt[RW];
    int e_idx[RW];
    int g_x[32];
    int g_w[32];
    int n_g;

    function automatic int base_per(int x, int y);
        bit nxt;
        nxt = (y < AY - 1) || (y == RH - 1);
        if (x < AX && y < AY) return 6;
        if (nxt && x >= RW - 10 && x <= RW - 3) return 4;
        if (nxt && x >= RW - 2) return 5;
        return 0;
    endfunction

    function automatic logic [3:0] ctl_of(int per);
        if (per == 1) return 4'b0101;
        if (per == 4) return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic plan_line(int y, int ax, int asrc, int acnt);
        int mp[NR];
        bit applied;
        bit any;
        int p;
        int x;
        int w;
        for (int i = 0; i < NR; i++) mp[i] = pend[i];
        for (int i = 0; i < RW; i++) begin
            e_per[i] = base_per(i, y);
            e_gnt[i] = 0;
            e_idx[i] = 0;
        end
        n_g = 0;
        p = mptr;
        applied = 1'b0;
        if (ax <= IS) begin mp[asrc] += acnt; applied = 1'b1; end
        any = 1'b0;
        for (int i = 0; i < NR; i++) if (mp[i] > 0) any = 1'b1;
        if (any) begin
            for (int i = 0; i < 8; i++) e_per[IS + i] = 1;
            e_per[IS + 8] = 2;
            e_per[IS + 9] = 2;
            x = IS + 10;
            for (int k = 0; k < MAXP; k++) begin
                if (!applied && ax <= x) begin mp[asrc] += acnt; applied = 1'b1; end
                w = -1;
                for (int i = 0; i < NR; i++)
                    if (w < 0 && mp[(p + i) % NR] > 0) w = (p + i) % NR;
                if (w < 0) break;
                for (int b = 0; b < 32; b++) begin
                    e_per[x + b] = 3;
                    e_gnt[x + b] = 1 << w;
                    e_idx[x + b] = b;
                end
                mp[w]--;
                p = (w + 1) % NR;
                g_x[n_g] = x;
                g_w[n_g] = w;
                n_g++;
                x += 32;
            end
            e_per[x]     = 2;
            e_per[x + 1] = 2;
        end
    endtask

    task automatic step(int x, int y, bit r, int per_e, int gnt_e, int idx_e,
                        bit ab_e, string tag);
        logic [18:0] obs;
        logic [18:0] expv;
        cx  = CW'(x);
        cy  = CW'(y);
        rst = r;
        for (int i = 0; i < NR; i++) req[i] = (pend[i] > 0);
        @(posedge clk);
        #1;
        obs  = {o_period, o_ctl, o_gnt, o_pkt_idx, o_pkt_first, o_pkt_last, o_abort};
        expv = {3'(per_e), ctl_of(per_e), 4'(gnt_e), 5'(idx_e),
                (per_e == 3 && idx_e == 0), (per_e == 3 && idx_e == 31), ab_e};
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s y=%0d x=%0d observed=%h expected=%h (period,ctl,gnt,idx,first,last,abort)",
                   tag, y, x, obs, expv);
        end
        for (int i = 0; i < NR; i++)
            if (o_gnt[i] && o_pkt_last && pend[i] > 0) pend[i]--;
    endtask

    task automatic run_line(int y, int xe, int ax, int asrc, int acnt, string tag);
        plan_line(y, ax, asrc, acnt);
        for (int x = 0; x <= xe; x++) begin
            if (x == ax) pend[asrc] += acnt;
            step(x, y, 1'b0, e_per[x], e_gnt[x], e_idx[x], 1'b0, tag);
        end
        for (int j = 0; j < n_g; j++)
            if (g_x[j] <= xe) mptr = (g_w[j] + 1) % NR;
    endtask

    task automatic set_pend(int v0, int v1, int v2, int v3);
        pend[0] = v0; pend[1] = v1; pend[2] = v2; pend[3] = v3;
    endtask

    initial begin
        rst = 1'b1;
        cx  = '0;
        cy  = '0;
        req = '0;
        set_pend(0, 0, 0, 0);

        // reset state
        step(0, 0, 1'b1, 0, 0, 0, 1'b0, "reset");
        step(1, 0, 1'b1, 0, 0, 0, 1'b0, "reset");
        mptr = 0;

        // idle active line: video, control, video preamble, guard
        run_line(10, RW - 1, NONE, 0, 0, "idle_line");

        // all four requesting: two packets per line, rotating
        set_pend(3, 3, 3, 3);
        run_line(12, RW - 1, NONE, 0, 0, "rr_line_a");
        run_line(13, RW - 1, NONE, 0, 0, "rr_line_b");
        set_pend(0, 0, 0, 0);

        // single requester from X=600, one packet
        run_line(14, RW - 1, 600, 2, 1, "single_pkt");

        // request arriving one cycle late waits a line
        run_line(15, RW - 1, IS + 1, 1, 1, "late_req");
        run_line(16, RW - 1, NONE, 0, 0, "late_req_next");

        // last active line and last frame line
        run_line(AY - 1, RW - 1, NONE, 0, 0, "y_last_active");
        run_line(RH - 1, RW - 1, NONE, 0, 0, "y_last_frame");

        // counter jump into the abort point mid-packet
        set_pend(0, 0, 1, 0);
        run_line(20, 670, NONE, 0, 0, "pre_abort");
        step(RW - 22, 20, 1'b0, 0, 0, 0, 1'b1, "abort_pulse");
        step(RW - 21, 20, 1'b0, 0, 0, 0, 1'b0, "abort_clear");
        set_pend(0, 0, 0, 0);

        // reset at beat 10 of a packet, then pointer restarts at 0
        set_pend(1, 1, 1, 1);
        run_line(21, IS + 10 + 10, NONE, 0, 0, "pre_reset");
        step(IS + 21, 21, 1'b1, 0, 0, 0, 1'b0, "mid_reset");
        mptr = 0;
        run_line(22, RW - 1, NONE, 0, 0, "post_reset");
        set_pend(0, 0, 0, 0);

        // randomized lines
        for (int n = 0; n < 10; n++) begin
            int y, ax, src, cnt;
            y   = int'($urandom_range(RH - 1, 0));
            ax  = int'($urandom_range(RW - 1, 0));
            src = int'($urandom_range(NR - 1, 0));
            cnt = int'($urandom_range(3, 0));
            run_line(y, RW - 1, ax, src, cnt, "random_line");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
